// File: rtl/cofre_pkg.sv
// Shared types and defaults for the lockout safe: state encoding, attempt
// classification and the timer-width helper.
package cofre_pkg;

    typedef enum logic [1:0] {
        ESPERA    = 2'b00,
        ABERTO    = 2'b01,
        BLOQUEADO = 2'b10
    } estado_t;

    typedef enum logic [1:0] {
        R_CERTO  = 2'b00,
        R_ERRADO = 2'b01,
        R_PERTO  = 2'b10,
        R_NADA   = 2'b11
    } resultado_t;

    localparam int MAX_FALHAS_PADRAO = 3;
    localparam int T_ABERTO_PADRAO   = 50;
    localparam int T_BLOQUEIO_PADRAO = 200;

    // Priority aberto > errado > perto; no flag at all is still a wrong attempt.
    function automatic resultado_t classificar(input logic aberto,
                                               input logic errado,
                                               input logic perto);
        if (aberto)      return R_CERTO;
        else if (errado) return R_ERRADO;
        else if (perto)  return R_PERTO;
        else             return R_NADA;
    endfunction

    // Bits needed to hold the larger of (a-1) and (b-1), never less than 1.
    function automatic int largura_timer(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cofre_bloqueio_temporizador.sv
// Down-counter with synchronous load, count enable and zero flag; one instance
// is shared by the ABERTO and BLOQUEADO dwell times.
module temporizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         carregar,
    input  logic         habilitar,
    input  logic [W-1:0] carga,
    output logic         zero
);

    logic [W-1:0] contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= carga;
        end else if (habilitar && (contagem != '0)) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/cofre_bloqueio.sv
// Safe controller: opens on a correct attempt, locks out after MAX_FALHAS
// consecutive wrong ones. Optional hint LED enabled by macro COFRE_DICA_EN.
module cofre_bloqueio
    import cofre_pkg::*;
#(
    parameter int MAX_FALHAS = MAX_FALHAS_PADRAO,
    parameter int T_ABERTO   = T_ABERTO_PADRAO,
    parameter int T_BLOQUEIO = T_BLOQUEIO_PADRAO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tentar,
    input  logic       aberto,
    input  logic       perto,
    input  logic       errado,
    input  logic       fechar,
    output logic       liberado,
    output logic       travado,
    output logic       dica,
    output logic [3:0] falhas,
    output logic [1:0] estado
);

    localparam int TW = largura_timer(T_ABERTO, T_BLOQUEIO);
    localparam logic [TW-1:0] CARGA_ABERTO    = TW'(T_ABERTO - 1);
    localparam logic [TW-1:0] CARGA_BLOQUEIO  = TW'(T_BLOQUEIO - 1);
    localparam logic [3:0]    LIMITE          = 4'(MAX_FALHAS);

    estado_t    estado_q, estado_d;
    logic [3:0] falhas_q, falhas_d;
    logic [3:0] falhas_inc;
    logic       liberado_q, travado_q;
    logic       carregar, habilitar, zero, aceito;
    logic [TW-1:0] carga;
    resultado_t resultado;

    // tentar is a single-cycle strobe: flags are only meaningful, and only
    // sampled, in a cycle where tentar=1 and the FSM is in ESPERA.
    assign resultado  = classificar(aberto, errado, perto);
    assign falhas_inc = falhas_q + 4'd1;

    temporizador #(.W(TW)) u_temporizador (
        .clk       (clk),
        .rst_n     (rst_n),
        .carregar  (carregar),
        .habilitar (habilitar),
        .carga     (carga),
        .zero      (zero)
    );

    always_comb begin
        estado_d  = estado_q;
        falhas_d  = falhas_q;
        carregar  = 1'b0;
        habilitar = 1'b0;
        carga     = '0;
        aceito    = 1'b0;
        case (estado_q)
            ESPERA: begin
                if (tentar) begin
                    aceito = 1'b1;
                    if (resultado == R_CERTO) begin
                        estado_d = ABERTO;
                        falhas_d = 4'd0;
                        carregar = 1'b1;
                        carga    = CARGA_ABERTO;
                    end else begin
                        falhas_d = falhas_inc;
                        if (falhas_inc == LIMITE) begin
                            estado_d = BLOQUEADO;
                            carregar = 1'b1;
                            carga    = CARGA_BLOQUEIO;
                        end
                    end
                end
            end
            ABERTO: begin
                habilitar = 1'b1;
                // fechar on the final cycle coincides with the timeout: one exit either way
                if (fechar || zero) begin
                    estado_d = ESPERA;
                end
            end
            BLOQUEADO: begin
                habilitar = 1'b1;
                if (zero) begin
                    estado_d = ESPERA;
                    falhas_d = 4'd0;
                end
            end
            default: begin
                estado_d = ESPERA;
                falhas_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= ESPERA;
            falhas_q   <= 4'd0;
            liberado_q <= 1'b0;
            travado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            falhas_q   <= falhas_d;
            liberado_q <= (estado_d == ABERTO);
            travado_q  <= (estado_d == BLOQUEADO);
        end
    end

`ifdef COFRE_DICA_EN
    logic dica_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dica_q <= 1'b0;
        end else if (aceito) begin
            dica_q <= (resultado != R_CERTO) && perto && (estado_d != BLOQUEADO);
        end
    end

    assign dica = dica_q;
`else
    logic aceito_sem_uso;
    assign aceito_sem_uso = aceito;
    assign dica = 1'b0;
`endif

    assign liberado = liberado_q;
    assign travado  = travado_q;
    assign falhas   = falhas_q;
    assign estado   = estado_q;

endmodule

// File: tb/tb_cofre_bloqueio.sv
// Randomised + directed bench for cofre_bloqueio against a time-stamp based
// reference model; honours COFRE_DICA_EN like the design.
module tb_cofre_bloqueio;

    localparam int MAXF = 3;
    localparam int TA   = 4;
    localparam int TB   = 8;
    localparam int W    = 9;
`ifdef COFRE_DICA_EN
    localparam bit DICA_EN = 1'b1;
`else
    localparam bit DICA_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tentar = 1'b0, aberto = 1'b0, perto = 1'b0, errado = 1'b0, fechar = 1'b0;
    logic       liberado, travado, dica;
    logic [3:0] falhas;
    logic [1:0] estado;

    cofre_bloqueio #(
        .MAX_FALHAS (MAXF),
        .T_ABERTO   (TA),
        .T_BLOQUEIO (TB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tentar   (tentar),
        .aberto   (aberto),
        .perto    (perto),
        .errado   (errado),
        .fechar   (fechar),
        .liberado (liberado),
        .travado  (travado),
        .dica     (dica),
        .falhas   (falhas),
        .estado   (estado)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: mode 0 idle, 1 open, 2 locked; m_fim is the absolute edge of exit
    int m_modo = 0, m_fim = 0, m_falhas = 0, ciclo = 0;
    bit m_dica = 0;
    logic [W-1:0] exp_q[$];
    int total = 0, bad = 0;

    function automatic logic [W-1:0] esperado();
        logic [3:0] f;
        logic [1:0] e;
        f = 4'(m_falhas);
        e = 2'(m_modo);
        return {m_modo == 1, m_modo == 2, m_dica, f, e};
    endfunction

    task automatic modelo_reset();
        m_modo = 0; m_falhas = 0; m_dica = 0;
    endtask

    task automatic modelo_borda(input bit t, input bit a, input bit p, input bit f);
        if (m_modo == 1) begin
            if (f || ciclo == m_fim) m_modo = 0;
        end else if (m_modo == 2) begin
            if (ciclo == m_fim) begin m_modo = 0; m_falhas = 0; end
        end else if (t) begin
            if (a) begin
                m_modo = 1; m_fim = ciclo + TA; m_falhas = 0; m_dica = 0;
            end else begin
                m_falhas = m_falhas + 1;
                m_dica = DICA_EN && p;
                if (m_falhas == MAXF) begin
                    m_modo = 2; m_fim = ciclo + TB; m_dica = 0;
                end
            end
        end
    endtask

    // driver: apply inputs for one cycle, update model at the edge, queue expectation
    task automatic passo(input bit t, input bit a, input bit p, input bit e, input bit f);
        tentar = t; aberto = a; perto = p; errado = e; fechar = f;
        @(posedge clk);
        ciclo++;
        modelo_borda(t, a, p, f);
        exp_q.push_back(esperado());
        #1;
        tentar = 0; aberto = 0; perto = 0; errado = 0; fechar = 0;
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) passo(0, 0, 0, 0, 0);
    endtask

    task automatic checar_direto(input string nome);
        logic [W-1:0] got, exp;
        got = {liberado, travado, dica, falhas, estado};
        exp = esperado();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b expected=%b (lib,trav,dica,falhas,estado)", nome, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] got, exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {liberado, travado, dica, falhas, estado};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL ciclo%0d got=%b expected=%b (lib,trav,dica,falhas,estado)",
                         ciclo, got, exp);
            end
        end
    end

    initial begin
        modelo_reset();
        #2;
        checar_direto("reset_inicial");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // correct attempt
        passo(1, 1, 0, 0, 0);
        ocioso(6);
        // lockout, with an ignored correct attempt inside it
        passo(1, 0, 0, 1, 0);
        passo(1, 0, 0, 1, 0);
        passo(1, 0, 0, 1, 0);
        ocioso(2);
        passo(1, 1, 0, 0, 0);
        ocioso(8);
        // close early in the 2nd open cycle, then immediate new attempt
        passo(1, 1, 0, 0, 0);
        passo(0, 0, 0, 0, 0);
        passo(0, 0, 0, 0, 1);
        passo(1, 1, 0, 0, 0);
        ocioso(5);
        // close on the last open cycle
        passo(1, 1, 0, 0, 0);
        ocioso(3);
        passo(0, 0, 0, 0, 1);
        ocioso(2);
        // fechar outside ABERTO is ignored; attempt with no flag counts as wrong
        passo(0, 0, 0, 0, 1);
        passo(1, 0, 0, 0, 0);
        // hint then correct attempt
        passo(1, 0, 1, 1, 0);
        passo(0, 0, 0, 0, 0);
        passo(1, 1, 0, 0, 0);
        ocioso(5);
        // reset during 5th lockout cycle
        passo(1, 0, 1, 0, 0);
        passo(1, 0, 0, 1, 0);
        passo(1, 0, 1, 1, 0);
        ocioso(4);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        modelo_reset();
        checar_direto("reset_bloqueio");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        passo(1, 1, 0, 0, 0);
        ocioso(5);

        // random phase
        for (int i = 0; i < 400; i++) begin
            bit t, a, p, e, f;
            t = ($urandom_range(0, 9) < 4);
            a = ($urandom_range(0, 3) == 0);
            p = $urandom_range(0, 1);
            e = $urandom_range(0, 1);
            f = ($urandom_range(0, 7) == 0);
            passo(t, a, p, e, f);
        end

        @(negedge clk); #2;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL fila_restante got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cofre_bloqueio.md
COFRE_BLOQUEIO -- requirements
Module: cofre_bloqueio

Interface
REQ-001 The module SHALL have parameter MAX_FALHAS, default 3: consecutive wrong attempts that trigger lockout (legal range 1..15).
REQ-002 The module SHALL have parameter T_ABERTO, default 50: number of cycles the safe stays open (at least 1).
REQ-003 The module SHALL have parameter T_BLOQUEIO, default 200: number of cycles the lockout lasts (at least 1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port tentar, input, 1 bit: one-cycle strobe marking a valid attempt result.
REQ-007 The module SHALL have port aberto, input, 1 bit: comparator says the attempt equals the password.
REQ-008 The module SHALL have port perto, input, 1 bit: comparator says the attempt is within 3 units of the password.
REQ-009 The module SHALL have port errado, input, 1 bit: comparator says the attempt is wrong.
REQ-010 The module SHALL have port fechar, input, 1 bit: user request to close an open safe.
REQ-011 The module SHALL have port liberado, output, 1 bit: safe open.
REQ-012 The module SHALL have port travado, output, 1 bit: lockout active.
REQ-013 The module SHALL have port dica, output, 1 bit: "close" hint LED.
REQ-014 The module SHALL have port falhas, output, 4 bits: current count of consecutive wrong attempts.
REQ-015 The module SHALL have port estado, output, 2 bits: FSM state with ESPERA=00, ABERTO=01, BLOQUEADO=10.

Function
REQ-016 The FSM SHALL have exactly three states (ESPERA, ABERTO, BLOQUEADO); code 11 is unreachable and SHALL recover to ESPERA on the next edge.
REQ-017 tentar SHALL be honoured only in ESPERA; in ABERTO or BLOQUEADO it SHALL be ignored, with no queuing and no effect on falhas.
REQ-018 Input priority on an accepted tentar: aberto over errado over perto; tentar with no flag set SHALL count as wrong.
REQ-019 ESPERA, tentar=1, aberto=1: the FSM SHALL go to ABERTO at the next edge and clear falhas to 0; liberado SHALL be 1 for exactly T_ABERTO cycles, then return to ESPERA.
REQ-020 ESPERA, tentar=1, wrong attempt: falhas SHALL increment at the next edge; if the new value equals MAX_FALHAS, the FSM SHALL enter BLOQUEADO at that same edge.
REQ-021 In BLOQUEADO, travado SHALL be 1 for exactly T_BLOQUEIO cycles; falhas SHALL hold MAX_FALHAS and clear to 0 when the FSM returns to ESPERA.
REQ-022 fechar=1 in ABERTO SHALL force ESPERA at the next edge and override the remaining timer; fechar in other states SHALL be ignored.
REQ-023 If fechar arrives on the last ABERTO cycle, the result SHALL be a single transition to ESPERA, with no extra cycle.
REQ-024 The timer SHALL be a down-counter loaded with T-1 on state entry; the state SHALL exit when the count is 0 at an edge.
REQ-025 All outputs SHALL be registered; latency from an accepted tentar to any output change SHALL be 1 cycle.
REQ-026 Input flags SHALL be sampled only in the cycle where tentar=1.

Reset
REQ-027 While rst_n=0, outputs SHALL immediately be: estado=ESPERA, liberado=0, travado=0, dica=0, falhas=0, timer=0.
REQ-028 Reset asserted mid-ABERTO or mid-BLOQUEADO SHALL abort the state with no residual count; rst_n deassertion SHALL take effect at the first clk edge after release.

Configuration
REQ-029 The hint feature SHALL be controlled by the macro COFRE_DICA_EN.
REQ-030 With COFRE_DICA_EN defined: a wrong accepted attempt with perto=1 SHALL set dica=1 at the next edge; dica SHALL clear on the next accepted tentar, on entry to BLOQUEADO, or on reset.
REQ-031 Without COFRE_DICA_EN: dica SHALL be constant 0, and no hint register SHALL be synthesized.

Structure
REQ-032 Package cofre_pkg SHALL hold the estado_t encoding (ESPERA, ABERTO, BLOQUEADO) and the default constants for MAX_FALHAS, T_ABERTO and T_BLOQUEIO.
REQ-033 Sub-module temporizador SHALL provide the parameterised-width down-counter with load, enable and zero flag; it is instantiated once and shared between ABERTO and BLOQUEADO.

Verification (bench parameters: MAX_FALHAS=3, T_ABERTO=4, T_BLOQUEIO=8)
REQ-034 Correct attempt: tentar+aberto in ESPERA -> liberado=1 for exactly 4 cycles starting the next cycle, then estado=00, falhas=0.
REQ-035 Lockout: three tentar+errado pulses -> falhas goes 1, 2, 3; travado=1 for exactly 8 cycles; during lockout a tentar+aberto is ignored; afterwards falhas=0.
REQ-036 Close early: fechar in the 2nd ABERTO cycle -> estado=00 at the next edge, and a new tentar is accepted immediately.
REQ-037 Hint: with COFRE_DICA_EN, tentar+errado+perto -> dica=1 next cycle, then tentar+aberto -> dica=0; without the macro, dica stays 0 throughout.
REQ-038 Reset mid-lockout: rst_n=0 in the 5th BLOQUEADO cycle -> travado=0 and falhas=0 asynchronously; after release a tentar+aberto opens the safe.
